// File: rtl/yconfig_loader.sv
// Streams per-column configuration slices into a yblock array as confclk/cbitin, holding arr_reset through the load.
// Optional readback of the bottom-row cbitout during each shift: define YCONFIG_READBACK_EN.
module yconfig_loader #(
  parameter int BLOCKWIDTH  = 8,
  parameter int BLOCKHEIGHT = 8,
  parameter int DIVIDER     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [BLOCKWIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  arr_reset,
  output logic                  confclk,
  output logic [BLOCKWIDTH-1:0] cbitin,
  input  logic [BLOCKWIDTH-1:0] cbitout,
  output logic [BLOCKWIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  localparam int NSLICE = 3 * BLOCKHEIGHT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int PW     = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NSLICE - 1);
  localparam logic [PW-1:0] PH_INIT = PW'(DIVIDER - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_RELEASE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_in_ready;
  logic                  w_ph_end;
  logic                  w_last;
  logic                  w_rise;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_arr_reset;
  logic                  r_confclk;
  logic [BLOCKWIDTH-1:0] r_cbitin;
  logic [CW-1:0]         r_cnt;
  logic [PW-1:0]         r_phase;

  assign w_ph_end = (r_phase == '0);
  assign w_last   = (r_cnt == LAST);
  assign w_rise   = (r_state == S_SETUP) && w_ph_end;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:    if (start && !r_busy) w_next = S_LOAD;
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = S_SETUP;
      end
      S_SETUP:   if (w_ph_end) w_next = S_HIGH;
      S_HIGH:    if (w_ph_end) w_next = w_last ? S_RELEASE : S_LOAD;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // busy stays up through the done cycle, so a start coinciding with done is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_arr_reset <= 1'b1;
      r_confclk   <= 1'b0;
      r_cbitin    <= '0;
      r_cnt       <= '0;
      r_phase     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_busy) begin
            r_busy      <= 1'b1;
            r_arr_reset <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_cbitin <= in_data;
            r_phase  <= PH_INIT;
          end
        end
        S_SETUP: begin
          if (w_ph_end) begin
            r_confclk <= 1'b1;
            r_phase   <= PH_INIT;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        S_HIGH: begin
          if (w_ph_end) begin
            r_confclk <= 1'b0;
            r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        S_RELEASE: begin
          r_arr_reset <= 1'b0;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = w_in_ready;
  assign arr_reset = r_arr_reset;
  assign confclk   = r_confclk;
  assign cbitin    = r_cbitin;

`ifdef YCONFIG_READBACK_EN
  logic [BLOCKWIDTH-1:0] r_rb_data;
  logic                  r_rb_valid;

  // cbitout is captured on the same edge confclk rises, i.e. before the array shifts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= w_rise;
      if (w_rise) r_rb_data <= cbitout;
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_cbitout;
  logic w_unused_rise;
  assign w_unused_cbitout = ^cbitout;
  assign w_unused_rise    = w_rise;
  assign rb_data          = '0;
  assign rb_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_yconfig_loader.sv
// Directed bench for yconfig_loader: DIVIDER=1 and DIVIDER=3 instances on a 2x2 block, with a yblock shift-chain model.
module tb_yconfig_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       start1 = 1'b0, in_valid1 = 1'b0;
  logic [1:0] in_data1 = '0;
  logic       busy1, done1, in_ready1, arr_reset1, confclk1, rb_valid1;
  logic [1:0] cbitin1, cbitout1, rb_data1;

  logic       start3 = 1'b0, in_valid3 = 1'b0;
  logic [1:0] in_data3 = '0;
  logic       busy3, done3, in_ready3, arr_reset3, confclk3, rb_valid3;
  logic [1:0] cbitin3, rb_data3;
  logic [1:0] cbitout3 = '0;

  logic [1:0] exp_q[$];
  logic [1:0] rb_q[$];
  bit         rb_armed = 1'b0;
  int         pulses1 = 0;
  int         fall_cyc = -100;
  logic       prev_cc1 = 1'b0;
  logic [1:0] hi_val = '0;
  logic [5:0] sr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  yconfig_loader #(.BLOCKWIDTH(2), .BLOCKHEIGHT(2), .DIVIDER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .arr_reset(arr_reset1), .confclk(confclk1), .cbitin(cbitin1),
    .cbitout(cbitout1), .rb_data(rb_data1), .rb_valid(rb_valid1));

  yconfig_loader #(.BLOCKWIDTH(2), .BLOCKHEIGHT(2), .DIVIDER(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .arr_reset(arr_reset3), .confclk(confclk3), .cbitin(cbitin3),
    .cbitout(cbitout3), .rb_data(rb_data3), .rb_valid(rb_valid3));

  // 2x2 yblock model: each column is a 6-bit chain shifting on confclk rise
  initial begin
    sr[0] = '0;
    sr[1] = '0;
  end
  always @(posedge confclk1) begin
    sr[0] <= {sr[0][4:0], cbitin1[0]};
    sr[1] <= {sr[1][4:0], cbitin1[1]};
  end
  assign cbitout1 = {sr[1][5], sr[0][5]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every confclk rise must deliver the next queued slice
  always @(negedge clk) begin
    if (confclk1 && !prev_cc1) begin
      pulses1++;
      hi_val = cbitin1;
      if (exp_q.size() == 0) check("extra_confclk_pulse", 32'(pulses1), 32'(0));
      else check("cbitin_at_rise", 32'(cbitin1), 32'(exp_q.pop_front()));
`ifdef YCONFIG_READBACK_EN
      check("rb_valid_at_rise", 32'(rb_valid1), 32'(1));
      if (rb_armed) begin
        if (rb_q.size() == 0) check("rb_extra", 32'(rb_data1), 32'hFFFF);
        else check("rb_data", 32'(rb_data1), 32'(rb_q.pop_front()));
      end
`else
      check("rb_tied_zero", 32'({rb_valid1, rb_data1}), 32'(0));
`endif
    end else begin
      if (confclk1) check("cbitin_stable_high", 32'(cbitin1), 32'(hi_val));
`ifdef YCONFIG_READBACK_EN
      if (rb_valid1) check("rb_valid_stray", 32'(rb_valid1), 32'(0));
`endif
    end
    if (!confclk1 && prev_cc1) fall_cyc = cyc;
    prev_cc1 = confclk1;
  end

  task automatic send1(input logic [1:0] v, output int hs);
    int n = 0;
    in_data1  = v;
    in_valid1 = 1'b1;
    while (in_ready1 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_timeout", 32'(n < 50), 32'(1));
    exp_q.push_back(v);
    hs = cyc;
    tick();
  endtask

  task automatic start_load1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("busy_after_start", 32'(busy1), 32'(1));
    check("in_ready_in_load", 32'(in_ready1), 32'(1));
  endtask

  task automatic wait_done1(input bit poke_start);
    int n = 0;
    in_valid1 = 1'b0;
    while (done1 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(n < 30), 32'(1));
    check("done_one_after_fall", 32'(cyc - fall_cyc), 32'(1));
    check("arr_reset_released", 32'(arr_reset1), 32'(0));
    check("busy_during_done", 32'(busy1), 32'(1));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    if (poke_start) start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("done_single_pulse", 32'(done1), 32'(0));
    check("busy_dropped", 32'(busy1), 32'(0));
    check("arr_reset_held_low", 32'(arr_reset1), 32'(0));
  endtask

  task automatic send3(input logic [1:0] v);
    int n = 0;
    in_data3  = v;
    in_valid3 = 1'b1;
    while (in_ready3 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("in_ready3_timeout", 32'(n < 50), 32'(1));
    tick();
    in_valid3 = 1'b0;
    check("cbitin3_loaded", 32'(cbitin3), 32'(v));
    for (int k = 0; k < 3; k++) begin
      check("div3_setup_low", 32'(confclk3), 32'(0));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check("div3_high", 32'(confclk3), 32'(1));
      check("div3_cbitin_stable", 32'(cbitin3), 32'(v));
      tick();
    end
    check("div3_fall", 32'(confclk3), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] pat [6];
    int hs, prev, p0;
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11;
    pat[3] = 2'b00; pat[4] = 2'b01; pat[5] = 2'b10;
    hs = 0;
    prev = 0;

    tick(); tick();
    reset = 1'b0;
    check("rst_arr_reset", 32'(arr_reset1), 32'(1));
    check("rst_confclk", 32'(confclk1), 32'(0));
    check("rst_in_ready", 32'(in_ready1), 32'(0));
    check("rst_busy", 32'(busy1), 32'(0));
    check("rst_done", 32'(done1), 32'(0));
    check("rst_cbitin", 32'(cbitin1), 32'(0));
    check("rst_rb", 32'({rb_valid1, rb_data1}), 32'(0));
    check("rst3_arr_reset", 32'(arr_reset3), 32'(1));

    // Back-to-back load with in_valid held high
    p0 = pulses1;
    start_load1();
    for (int i = 0; i < 6; i++) begin
      send1(pat[i], hs);
      if (i > 0) check("handshake_spacing", 32'(hs - prev), 32'(3));
      prev = hs;
    end
    wait_done1(1'b0);
    check("t1_pulse_count", 32'(pulses1 - p0), 32'(6));

    // Producer stall after the third slice
    p0 = pulses1;
    start_load1();
    for (int i = 0; i < 3; i++) send1(pat[i], hs);
    in_valid1 = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check("gap_confclk_low", 32'(confclk1), 32'(0));
      check("gap_cbitin_hold", 32'(cbitin1), 32'(2'b11));
      check("gap_in_ready", 32'(in_ready1), 32'(1));
      tick();
    end
    check("gap_pulse_count", 32'(pulses1 - p0), 32'(3));
    for (int i = 3; i < 6; i++) send1(pat[i], hs);
    wait_done1(1'b0);
    check("t2_pulse_count", 32'(pulses1 - p0), 32'(6));

    // Reset during slice 4 high phase, then a clean reload
    start_load1();
    for (int i = 0; i < 4; i++) send1(pat[i], hs);
    in_valid1 = 1'b0;
    tick();
    check("abort_in_high", 32'(confclk1), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_confclk", 32'(confclk1), 32'(0));
    check("abort_arr_reset", 32'(arr_reset1), 32'(1));
    check("abort_busy", 32'(busy1), 32'(0));
    check("abort_done", 32'(done1), 32'(0));
    tick();
    check("abort_no_done", 32'(done1), 32'(0));
    check("abort_idle", 32'(in_ready1), 32'(0));
    exp_q.delete();
    p0 = pulses1;
    start_load1();
    for (int i = 0; i < 6; i++) send1(pat[i], hs);
    wait_done1(1'b0);
    check("t3_pulse_count", 32'(pulses1 - p0), 32'(6));

    // Spurious start and in_valid outside LOAD
    p0 = pulses1;
    in_data1  = 2'b11;
    in_valid1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_in_ready_low", 32'(in_ready1), 32'(0));
    end
    in_valid1 = 1'b0;
    check("idle_no_pulse", 32'(pulses1 - p0), 32'(0));
    start_load1();
    send1(pat[0], hs);
    in_valid1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 1; i < 6; i++) send1(pat[i], hs);
    wait_done1(1'b1);
    tick();
    check("start_at_done_ignored", 32'(in_ready1), 32'(0));
    check("t4_pulse_count", 32'(pulses1 - p0), 32'(6));

    // DIVIDER=3 timing
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("busy3_after_start", 32'(busy3), 32'(1));
    for (int i = 0; i < 6; i++) send3(pat[i]);
    begin
      int n = 0;
      while (done3 !== 1'b1 && n < 30) begin
        tick();
        n++;
      end
      check("done3_timeout", 32'(n < 30), 32'(1));
    end
    check("arr_reset3_released", 32'(arr_reset3), 32'(0));
    tick();
    check("busy3_dropped", 32'(busy3), 32'(0));
    check("rb3_quiet", 32'({rb_valid3, rb_data3}), 32'(0));

`ifdef YCONFIG_READBACK_EN
    // Load A twice; the second pass must read A back in order
    start_load1();
    for (int i = 0; i < 6; i++) send1(pat[i], hs);
    wait_done1(1'b0);
    for (int i = 0; i < 6; i++) rb_q.push_back(pat[i]);
    rb_armed = 1'b1;
    start_load1();
    for (int i = 0; i < 6; i++) send1(pat[i], hs);
    wait_done1(1'b0);
    rb_armed = 1'b0;
    check("rb_all_seen", 32'(rb_q.size()), 32'(0));
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yconfig_loader.md
Name: yconfig_loader

Overview:
- Upstream feeder for a yblock array: turns a valid/ready stream of per-column configuration slices into the `confclk` strobe and `cbitin` vector that shift 3-bit cell configurations down each column.
- Holds the array frozen through its `reset` input for the whole load, then releases it.
- Sits between the system-side configuration source (bus bridge / ROM streamer) and the yblock's `confclk`, `cbitin` and `reset` pins.

Parameters:
- BLOCKWIDTH, 8, columns in the target block; width of each slice.
- BLOCKHEIGHT, 8, rows in the target block; a full load is 3*BLOCKHEIGHT slices.
- DIVIDER, 2, clk cycles per `confclk` phase (low setup and high), minimum 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a full load.
- busy  output  1  high from the accepted start until the cycle after done.
- done  output  1  one-cycle pulse when the load completes.
- in_data  input  BLOCKWIDTH  slice: bit x goes to column x.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- arr_reset  output  1  drives the array's reset; freezes the array while high.
- confclk  output  1  configuration strobe to the array; registered, glitch-free.
- cbitin  output  BLOCKWIDTH  configuration bits to the top row of the array.
- cbitout  input  BLOCKWIDTH  bits shifted out of the bottom row of the array.
- rb_data  output  BLOCKWIDTH  readback slice (optional feature).
- rb_valid  output  1  rb_data valid pulse (optional feature).

Behaviour:
- Clocking and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, in_ready=0, confclk=0, cbitin=0, arr_reset=1, rb_data=0, rb_valid=0, slice counter=0. An unloaded array stays frozen.
- Reset mid-load: the load is abandoned and the state above applies on the next edge. confclk drops at once. No partial release of arr_reset.
- States and transitions:
  - IDLE: start=1 -> LOAD, busy<=1, arr_reset<=1. start while busy is ignored.
  - LOAD: in_ready=1 (combinational from state). On in_valid&in_ready: cbitin<=in_data, phase counter<=DIVIDER-1, -> SETUP.
  - SETUP: confclk=0 for DIVIDER cycles (cbitin setup time). Then confclk<=1, -> HIGH.
  - HIGH: confclk=1 for DIVIDER cycles. Then confclk<=0.
    - If slice counter == 3*BLOCKHEIGHT-1: counter<=0, -> RELEASE.
    - Else: counter+1, -> LOAD.
  - RELEASE: one cycle. arr_reset<=0, done<=1, -> IDLE. busy drops with done's falling edge.
- Data hold: cbitin holds its last value between slices and after done. It changes only on a handshake, so it is never changing while confclk is high.
- Throughput: minimum slice period is 2*DIVIDER+1 clk cycles. A stall on in_valid lengthens LOAD only; confclk stays low.
- Bit placement: slice k lands in row BLOCKHEIGHT-1-floor(k/3), cell config bit 2-(k mod 3). Software therefore sends the bottom row first, msb first.
- Counter width: clog2(3*BLOCKHEIGHT).
- Simultaneous events: start together with reset -> reset wins. in_valid outside LOAD is ignored, with no data loss on the producer side because in_ready=0.

Optional Feature:
- Macro: YCONFIG_READBACK_EN.
- With the macro:
  - On each confclk rising edge (HIGH entry), cbitout is sampled into rb_data and rb_valid pulses for one cycle. There is no backpressure.
  - The array's previous configuration therefore streams out, in the same order it was loaded, while the new one shifts in.
  - Loading twice with identical data lets the bench verify the chain.
- Without the macro: rb_data=0 and rb_valid=0 are tied constant, cbitout is unused, and no sampling flops exist.

Test Plan:
1. BLOCKWIDTH=2, BLOCKHEIGHT=2, DIVIDER=1. After reset, check arr_reset=1, confclk=0, in_ready=0. Pulse start, then stream 6 slices {2'b01,2'b10,2'b11,2'b00,2'b01,2'b10} with in_valid held high. Required: exactly 6 confclk pulses; in_ready high 1 cycle in every 3; done pulses once, 1 cycle after the 6th confclk fall; arr_reset=0 from that same edge.
2. Same stimulus, with in_valid dropped for 5 cycles after slice 3. Required: confclk stays low during the gap, there is no extra pulse, and cbitin stays 2'b11 until slice 4 is accepted.
3. Assert reset during slice 4's HIGH phase. Required: next edge gives confclk=0, arr_reset=1, busy=0, and no done. A new start followed by 6 slices completes normally.
4. Start pulsed while busy, and in_valid held in IDLE. Required: neither affects the slice count, and done arrives after exactly 6 handshakes.
5. DIVIDER=3. Required: confclk low 3 and high 3 cycles per slice, and cbitin stable throughout each high phase.
6. YCONFIG_READBACK_EN defined, with a 2×2 yblock model attached. Load pattern A, then load pattern A again. Required: the 6 rb_data values from the second load equal A in order, with one rb_valid per confclk rise.
